// File: rtl/vga_timing_decoder_if.sv
// vga_timing_decoder_if: sync/video inputs and recovered timing outputs of the VGA timing decoder.
interface vga_timing_decoder_if;
  logic hSync, vSync, bright;
  logic de, line_start, frame_start, locked, timing_error;
  logic [15:0] pixel_x, pixel_y, h_period, a_period, v_period;
  modport master(
    output hSync, vSync, bright,
    input de, pixel_x, pixel_y, line_start, frame_start, h_period, a_period, v_period, locked, timing_error
  );
  modport slave(
    input hSync, vSync, bright,
    output de, pixel_x, pixel_y, line_start, frame_start, h_period, a_period, v_period, locked, timing_error
  );
endinterface

// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder: recovers pixel coordinates, line/frame markers and period measurements from VGA syncs, and tracks lock.
module vga_timing_decoder #(
  parameter int H_TOTAL = 800,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL = 480,
  parameter int LOCK_FRAMES = 2
) (
  input logic clk,
  input logic reset,
  vga_timing_decoder_if.slave v
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state;
  logic hs_q, vs_q, first_line, frame_bad;
  logic [15:0] h_cnt, a_cnt, l_cnt, good_frames;
  logic hs_fall, vs_fall, sync_loss, line_bad, frame_good;
  logic [15:0] h_new, a_new, v_new;
  // h_new/a_new/v_new double as the counters' next values and the captured periods
  always_comb begin
    hs_fall = hs_q & ~v.hSync;
    vs_fall = vs_q & ~v.vSync;
    h_new = &h_cnt ? h_cnt : h_cnt + 16'd1;
    a_new = (&a_cnt || !v.bright) ? a_cnt : a_cnt + 16'd1;
    v_new = (&l_cnt || !hs_fall) ? l_cnt : l_cnt + 16'd1;
    sync_loss = !hs_fall && h_cnt == 16'(2 * H_TOTAL);
    line_bad = hs_fall && !first_line && (h_new != 16'(H_TOTAL) || a_new != 16'(H_ACTIVE));
    frame_good = v_new == 16'(V_TOTAL) && !frame_bad && !line_bad;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      h_cnt <= '0;
      a_cnt <= '0;
      l_cnt <= '0;
      good_frames <= '0;
      first_line <= 1'b1;
      frame_bad <= 1'b0;
      state <= SEARCH;
      v.de <= 1'b0;
      v.pixel_x <= '0;
      v.pixel_y <= '0;
      v.line_start <= 1'b0;
      v.frame_start <= 1'b0;
      v.h_period <= '0;
      v.a_period <= '0;
      v.v_period <= '0;
      v.locked <= 1'b0;
      v.timing_error <= 1'b0;
    end else begin
      hs_q <= v.hSync;
      vs_q <= v.vSync;
      h_cnt <= hs_fall ? '0 : h_new;
      a_cnt <= hs_fall ? '0 : a_new;
      l_cnt <= vs_fall ? '0 : v_new;
      v.de <= v.bright;
      v.pixel_x <= hs_fall ? '0 : a_cnt;
      v.pixel_y <= vs_fall ? '0 : (hs_fall && a_new != '0 && !(&v.pixel_y)) ? v.pixel_y + 16'd1 : v.pixel_y;
      v.line_start <= hs_fall;
      v.frame_start <= vs_fall;
      v.h_period <= hs_fall ? h_new : v.h_period;
      v.a_period <= hs_fall ? a_new : v.a_period;
      v.v_period <= vs_fall ? v_new : v.v_period;
      first_line <= hs_fall ? 1'b0 : first_line;
      frame_bad <= vs_fall ? 1'b0 : frame_bad | line_bad;
      v.timing_error <= 1'b0;
      // entering SEARCH re-arms first_line so the next (possibly partial) line is not judged
      case (state)
        SEARCH: if (vs_fall) begin
          state <= MEASURE;
          good_frames <= '0;
        end
        MEASURE: if (sync_loss) begin
          state <= SEARCH;
          first_line <= 1'b1;
        end else if (line_bad || (vs_fall && !frame_good)) begin
          good_frames <= '0;
        end else if (vs_fall) begin
          good_frames <= good_frames + 16'd1;
          if (good_frames + 16'd1 >= 16'(LOCK_FRAMES)) begin
            state <= LOCKED;
            v.locked <= 1'b1;
          end
        end
        LOCKED: if (sync_loss || line_bad || (vs_fall && !frame_good)) begin
          state <= SEARCH;
          first_line <= 1'b1;
          v.locked <= 1'b0;
          v.timing_error <= 1'b1;
        end
        default: state <= SEARCH;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_timing_decoder.sv
// tb_vga_timing_decoder: directed checks of the decoder on a scaled timing (20-clock lines, 10 active, 6 lines per frame).
module tb_vga_timing_decoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vecs = 0;
  int errs = 0;
  vga_timing_decoder_if bus();
  vga_timing_decoder #(.H_TOTAL(20), .H_ACTIVE(10), .V_TOTAL(6), .LOCK_FRAMES(2)) dut (
    .clk(clk),
    .reset(reset),
    .v(bus)
  );
  always #5 clk = ~clk;
  // inputs are applied between edges; on return the outputs reflect that cycle's inputs
  task automatic cyc(input logic hs, input logic vs, input logic br);
    bus.hSync = hs;
    bus.vSync = vs;
    bus.bright = br;
    @(posedge clk);
    #1;
  endtask
  // hSync low at h=0..2, bright from h=6 for nact cycles
  task automatic line(input int len, input int nact, input bit vlow, input int h0 = 0);
    for (int h = h0; h < len; h++) cyc(h >= 3, !vlow, h >= 6 && h < 6 + nact);
  endtask
  task automatic frame(input int h0 = 0);
    for (int l = 0; l < 6; l++) line(20, 10, l < 2, l == 0 ? h0 : 0);
  endtask
  task automatic edge0();
    cyc(1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) cyc(1'b1, 1'b1, 1'b1);
    vecs++; if (bus.de !== 1'b0) begin errs++; $display("FAIL reset_de got %0d exp 0", bus.de); end
    vecs++; if (bus.pixel_x !== 16'd0 || bus.pixel_y !== 16'd0) begin errs++; $display("FAIL reset_pixel got %0d,%0d exp 0,0", bus.pixel_x, bus.pixel_y); end
    vecs++; if ({bus.line_start, bus.frame_start} !== 2'b00) begin errs++; $display("FAIL reset_markers got %b exp 00", {bus.line_start, bus.frame_start}); end
    vecs++; if ({bus.h_period, bus.a_period, bus.v_period} !== 48'd0) begin errs++; $display("FAIL reset_periods got %0d,%0d,%0d exp 0,0,0", bus.h_period, bus.a_period, bus.v_period); end
    vecs++; if ({bus.locked, bus.timing_error} !== 2'b00) begin errs++; $display("FAIL reset_lock got %b exp 00", {bus.locked, bus.timing_error}); end
    reset = 1'b1;
    repeat (5) cyc(1'b1, 1'b1, 1'b0);
  endtask
  task automatic test_nominal();
    edge0();
    vecs++; if ({bus.line_start, bus.frame_start} !== 2'b11) begin errs++; $display("FAIL first_markers got %b exp 11", {bus.line_start, bus.frame_start}); end
    frame(1);
    edge0();
    vecs++; if (bus.h_period !== 16'd20) begin errs++; $display("FAIL nom_h_period got %0d exp 20", bus.h_period); end
    vecs++; if (bus.a_period !== 16'd10) begin errs++; $display("FAIL nom_a_period got %0d exp 10", bus.a_period); end
    vecs++; if (bus.v_period !== 16'd6) begin errs++; $display("FAIL nom_v_period got %0d exp 6", bus.v_period); end
    vecs++; if (bus.locked !== 1'b0) begin errs++; $display("FAIL nom_lock_early got %0d exp 0", bus.locked); end
    for (int l = 0; l < 6; l++)
      for (int h = (l == 0) ? 1 : 0; h < 20; h++) begin
        logic br;
        br = h >= 6 && h < 16;
        cyc(h >= 3, !(l < 2), br);
        vecs++; if (bus.de !== br) begin errs++; $display("FAIL de_mirror l=%0d h=%0d got %0d exp %0d", l, h, bus.de, br); end
        vecs++; if (bus.line_start !== (h == 0)) begin errs++; $display("FAIL line_start l=%0d h=%0d got %0d exp %0d", l, h, bus.line_start, h == 0); end
        if (br) begin
          vecs++; if (bus.pixel_x !== 16'(h - 6)) begin errs++; $display("FAIL pixel_x l=%0d h=%0d got %0d exp %0d", l, h, bus.pixel_x, h - 6); end
          vecs++; if (bus.pixel_y !== 16'(l)) begin errs++; $display("FAIL pixel_y l=%0d h=%0d got %0d exp %0d", l, h, bus.pixel_y, l); end
        end
      end
    vecs++; if (bus.locked !== 1'b0) begin errs++; $display("FAIL nom_lock_before got %0d exp 0", bus.locked); end
    edge0();
    vecs++; if (bus.locked !== 1'b1) begin errs++; $display("FAIL nom_lock got %0d exp 1", bus.locked); end
    vecs++; if (bus.timing_error !== 1'b0) begin errs++; $display("FAIL nom_err got %0d exp 0", bus.timing_error); end
    frame(1);
  endtask
  task automatic test_stretch();
    edge0();
    line(20, 10, 1'b1, 1);
    line(20, 10, 1'b1);
    line(21, 10, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    vecs++; if (bus.h_period !== 16'd21) begin errs++; $display("FAIL stretch_h_period got %0d exp 21", bus.h_period); end
    vecs++; if ({bus.timing_error, bus.locked} !== 2'b10) begin errs++; $display("FAIL stretch_err got %b exp 10", {bus.timing_error, bus.locked}); end
    cyc(1'b1, 1'b1, 1'b0);
    vecs++; if (bus.timing_error !== 1'b0) begin errs++; $display("FAIL stretch_pulse_len got %0d exp 0", bus.timing_error); end
    line(20, 10, 1'b0, 2);
    line(20, 10, 1'b0);
    line(20, 10, 1'b0);
    for (int f = 0; f < 3; f++) begin
      edge0();
      vecs++; if (bus.locked !== (f == 2)) begin errs++; $display("FAIL stretch_relock f=%0d got %0d exp %0d", f, bus.locked, f == 2); end
      frame(1);
    end
  endtask
  task automatic test_sync_loss();
    edge0();
    line(20, 10, 1'b1, 1);
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b1, 1'b1, 1'b0);
      vecs++; if (bus.timing_error !== (k == 22)) begin errs++; $display("FAIL loss_locked k=%0d got %0d exp %0d", k, bus.timing_error, k == 22); end
    end
    vecs++; if (bus.locked !== 1'b0) begin errs++; $display("FAIL loss_unlock got %0d exp 0", bus.locked); end
    edge0();
    frame(1);
    edge0();
    line(20, 10, 1'b1, 1);
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b1, 1'b1, 1'b0);
      vecs++; if (bus.timing_error !== 1'b0) begin errs++; $display("FAIL loss_measure k=%0d got %0d exp 0", k, bus.timing_error); end
    end
    edge0();
    vecs++; if (bus.locked !== 1'b0) begin errs++; $display("FAIL loss_measure_lock got %0d exp 0", bus.locked); end
    frame(1);
  endtask
  task automatic test_bad_active();
    edge0();
    line(20, 10, 1'b1, 1);
    line(20, 10, 1'b1);
    line(20, 10, 1'b0);
    line(20, 11, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    vecs++; if (bus.a_period !== 16'd11) begin errs++; $display("FAIL bad_a_period got %0d exp 11", bus.a_period); end
    vecs++; if (bus.timing_error !== 1'b0) begin errs++; $display("FAIL bad_a_err got %0d exp 0", bus.timing_error); end
    line(20, 10, 1'b0, 1);
    line(20, 10, 1'b0);
    for (int f = 0; f < 3; f++) begin
      edge0();
      vecs++; if (bus.locked !== (f == 2)) begin errs++; $display("FAIL bad_a_relock f=%0d got %0d exp %0d", f, bus.locked, f == 2); end
      frame(1);
    end
  endtask
  task automatic test_coincident();
    vecs++; if (bus.pixel_y !== 16'd5) begin errs++; $display("FAIL coin_last_y got %0d exp 5", bus.pixel_y); end
    edge0();
    vecs++; if ({bus.line_start, bus.frame_start, bus.locked, bus.timing_error} !== 4'b1110) begin errs++; $display("FAIL coin_flags got %b exp 1110", {bus.line_start, bus.frame_start, bus.locked, bus.timing_error}); end
    vecs++; if (bus.v_period !== 16'd6) begin errs++; $display("FAIL coin_v_period got %0d exp 6", bus.v_period); end
    for (int h = 1; h <= 6; h++) cyc(h >= 3, 1'b0, h >= 6);
    vecs++; if ({bus.de, bus.pixel_x, bus.pixel_y} !== {1'b1, 32'd0}) begin errs++; $display("FAIL coin_first_pixel got de=%0d x=%0d y=%0d exp 1,0,0", bus.de, bus.pixel_x, bus.pixel_y); end
    line(20, 10, 1'b1, 7);
    line(20, 10, 1'b1);
    for (int l = 2; l < 6; l++) line(20, 10, 1'b0);
  endtask
  task automatic test_reset_mid();
    edge0();
    line(20, 10, 1'b1, 1);
    line(20, 10, 1'b1);
    for (int h = 0; h < 10; h++) cyc(h >= 3, 1'b1, h >= 6);
    reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b1);
    vecs++; if ({bus.de, bus.line_start, bus.frame_start, bus.locked, bus.timing_error} !== 5'b0) begin errs++; $display("FAIL mid_reset_flags got %b exp 00000", {bus.de, bus.line_start, bus.frame_start, bus.locked, bus.timing_error}); end
    vecs++; if ({bus.pixel_x, bus.pixel_y, bus.h_period, bus.a_period, bus.v_period} !== 80'd0) begin errs++; $display("FAIL mid_reset_values got %0d,%0d,%0d,%0d,%0d exp 0", bus.pixel_x, bus.pixel_y, bus.h_period, bus.a_period, bus.v_period); end
    reset = 1'b1;
    for (int h = 11; h < 20; h++) begin
      cyc(1'b1, 1'b1, h < 16);
      vecs++; if ({bus.timing_error, bus.locked} !== 2'b00) begin errs++; $display("FAIL mid_partial h=%0d got %b exp 00", h, {bus.timing_error, bus.locked}); end
    end
    cyc(1'b0, 1'b1, 1'b0);
    vecs++; if ({bus.h_period, bus.a_period} !== {16'd10, 16'd5}) begin errs++; $display("FAIL mid_partial_periods got %0d,%0d exp 10,5", bus.h_period, bus.a_period); end
    vecs++; if (bus.timing_error !== 1'b0) begin errs++; $display("FAIL mid_partial_err got %0d exp 0", bus.timing_error); end
    line(20, 10, 1'b0, 1);
    line(20, 10, 1'b0);
    line(20, 10, 1'b0);
    for (int f = 0; f < 3; f++) begin
      edge0();
      vecs++; if (bus.locked !== (f == 2)) begin errs++; $display("FAIL mid_relock f=%0d got %0d exp %0d", f, bus.locked, f == 2); end
      frame(1);
    end
  endtask
  initial begin
    bus.hSync = 1'b1;
    bus.vSync = 1'b1;
    bus.bright = 1'b0;
    test_reset();
    test_nominal();
    test_stretch();
    test_sync_loss();
    test_bad_active();
    test_coincident();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/vga_timing_decoder.md
# vga_timing_decoder

Receive-side counterpart to the VGA sync generator. It consumes `hSync`, `vSync` and `bright` on the pixel clock and recovers active-pixel coordinates, the data-enable and line/frame markers. It also measures line, active and frame lengths, runs a lock state machine against the nominal timing, and flags timing errors. It sits downstream of the generator, or of any source on the same pixel clock, and feeds frame-capture and self-check logic.

## Interface
- `H_TOTAL`, 800, expected clocks per line (hSync fall to hSync fall)
- `H_ACTIVE`, 640, expected `bright` cycles per line
- `V_TOTAL`, 480, expected hSync falls per frame
- `LOCK_FRAMES`, 2, consecutive good frames required to lock
- `clk` in 1: pixel clock
- `reset` in 1: synchronous, active-low
- `hSync` in 1: horizontal sync, active-low, synchronous to `clk`
- `vSync` in 1: vertical sync, active-low, synchronous to `clk`
- `bright` in 1: active-video indicator
- `de` out 1: registered `bright`
- `pixel_x` out 16: active-pixel index within line, valid when `de`
- `pixel_y` out 16: active-line index within frame, valid when `de`
- `line_start` out 1: one-cycle pulse per hSync fall
- `frame_start` out 1: one-cycle pulse per vSync fall
- `h_period` out 16: last measured line length
- `a_period` out 16: last measured active count
- `v_period` out 16: last measured lines per frame
- `locked` out 1: timing matches parameters
- `timing_error` out 1: one-cycle pulse on loss of lock

## Operation
- No input synchronizers; inputs share `clk`.
- `hs_fall = hs_q & ~hSync`, where `hs_q` is last cycle's `hSync`; `vs_fall` is defined the same way. `hs_q` and `vs_q` reset to 1.
- `h_cnt`: on `hs_fall` it loads 0, otherwise it increments, saturating at 16'hFFFF. On `hs_fall`, `h_period <= h_cnt + 1`.
- `a_cnt` counts `bright` cycles in the line. On `hs_fall`, `a_period <= a_cnt + bright` and `a_cnt <= 0`.
- `l_cnt` increments on each `hs_fall`. On `vs_fall`, `v_period <= l_cnt + hs_fall` and `l_cnt <= 0`. This counts the hs_falls in the interval (previous vs_fall, this vs_fall], so it is independent of hSync/vSync phase.
- `pixel_x` equals the number of `bright` cycles earlier in the line and clears on `hs_fall`.
- `pixel_y` increments on `hs_fall` if the ending line had ≥1 `bright` cycle, and clears on `vs_fall`. When both occur in the same cycle, the clear wins.
- `line_ok`: evaluated at `hs_fall`. Requires `h_period` = `H_TOTAL` and `a_period` = `H_ACTIVE` (the newly captured values). It is ignored for the first hs_fall after reset or after entering SEARCH (partial line).
- `frame_ok`: evaluated at `vs_fall`. Requires `v_period` = `V_TOTAL` and every evaluated line in that frame ok.
- Loss of sync: `h_cnt` reaching `2*H_TOTAL` counts as a bad line.
- FSM:
  - SEARCH: on `vs_fall` → MEASURE with `good_frames = 0`.
  - MEASURE: a bad line or bad frame → `good_frames = 0`, stay in MEASURE. On a good frame, `good_frames++`; reaching `LOCK_FRAMES` → LOCKED.
  - LOCKED: a bad line, bad frame or sync loss → pulse `timing_error`, go to SEARCH.
  - Sync loss in MEASURE → SEARCH without an error pulse.
- `locked` = (state == LOCKED).
- Reset: all outputs are 0, all counters are 0, state is SEARCH, and the first-line flag is set.

## Timing
- All outputs are registered. Latency is 1 cycle from the input event: `de(t+1) = bright(t)`, and `line_start`/`frame_start` pulse at t+1 for a fall at t.
- `h_period`, `a_period`, `v_period` update at t+1 for the capturing fall at t.
- `locked` and `timing_error` change at t+1 for the deciding event at t.
- On simultaneous `hs_fall` and `vs_fall`, the line check is applied before the frame check. The frame includes that line.
- Reset mid-frame takes effect at the next edge, regardless of state. Lock must then be fully re-acquired: first vs_fall, then `LOCK_FRAMES` good frames.
- Counter saturation at 16'hFFFF is held, with no wrap.

## Test plan
- Nominal stimulus (800-clock lines, hSync low at h=0..95, `bright` at h=144..783, 480 lines, vSync low for the first 2 lines) → `h_period`=800, `a_period`=640, `v_period`=480. `locked` rises 1 cycle after the 2nd vs_fall following the first one. `pixel_x` sweeps 0..639, `pixel_y` sweeps 0..479, and `de` mirrors `bright` delayed 1 cycle.
- While locked, one line stretched to 801 clocks → `h_period`=801 and `timing_error`=1 for exactly 1 cycle. `locked`=0 on the same cycle, then relock after the next vs_fall plus 2 good frames.
- While locked, `hSync` held high for 1600 clocks → `timing_error` pulse at `h_cnt`=1600, `locked`=0. No error pulse if the same loss happens in MEASURE.
- One line with 641 `bright` cycles during MEASURE after one good frame → `good_frames` resets. `locked` rises only after 2 further good frames.
- vSync fall coincident with hSync fall in steady state → `v_period`=480, `pixel_y`=0 on the following `de`, with no error.
- Reset deasserted-low mid-frame while locked → next cycle all outputs are 0 and `locked`=0. After release, the first partial line raises no error.
